medidor_periodo: RTL



---
 rtl/pov_pkg.sv | 10 +
 rtl/sincro_flanco.sv | 27 ++
 rtl/medidor_periodo.sv | 90 +++++++++
 3 files changed

// File: rtl/pov_pkg.sv
// pov_pkg: shared FSM encoding and default timing parameters for the POV arm timing blocks.
package pov_pkg;
  typedef enum logic {
    ST_INICIO   = 1'b0,
    ST_MIDIENDO = 1'b1
  } estado_t;
  localparam int PRESC_DEF   = 50;
  localparam int ANCHO_DEF   = 20;
  localparam int MIN_PER_DEF = 16;
endpackage

// File: rtl/sincro_flanco.sv
// sincro_flanco: 2-flop synchronizer plus history flop; flanco is a 1-cycle pulse on a rising edge of in.
// Ports: Reloj (clock), nReset (async, active low), in (async level), flanco (rising-edge pulse).
module sincro_flanco (
  input  logic Reloj,
  input  logic nReset,
  input  logic in,
  output logic flanco
);
  logic s1_q, s2_q, h_q;
  logic s1_d, s2_d, h_d;
  always_comb begin
    s1_d = in;
    s2_d = s1_q;
    h_d  = s2_q;
  end
  always_ff @(posedge Reloj or negedge nReset)
    if (!nReset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      h_q  <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      h_q  <= h_d;
    end
  assign flanco = s2_q & ~h_q;
endmodule

// File: rtl/medidor_periodo.sv
// medidor_periodo: measures prescaled ticks between hall-sensor rising edges and publishes the period.
// Ports: Reloj (clock), nReset (async, active low), Pulso (async hall pulse),
//        Periodo (last accepted period), Valido (1-cycle update strobe),
//        Listo (a period is available), Parado (counter saturated, rotor stopped).
module medidor_periodo
  import pov_pkg::*;
#(
  parameter int PRESC   = PRESC_DEF,
  parameter int ANCHO   = ANCHO_DEF,
  parameter int MIN_PER = MIN_PER_DEF
) (
  input  logic             Reloj,
  input  logic             nReset,
  input  logic             Pulso,
  output logic [ANCHO-1:0] Periodo,
  output logic             Valido,
  output logic             Listo,
  output logic             Parado
);
  localparam int PW = PRESC > 1 ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRE_FIN = PW'(PRESC - 1);
  // The edge cycle itself is prescaler step 0, so the register restarts at 1;
  // this makes the captured count floor(D/PRESC).
  localparam logic [PW-1:0] PRE_ARR = PW'(PRESC > 1 ? 1 : 0);
  localparam logic [ANCHO-1:0] CONT_MAX = '1;
  localparam logic [ANCHO-1:0] CONT_MIN = ANCHO'(MIN_PER);
  estado_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [ANCHO-1:0] cont_q, cont_d, cont_inc, periodo_q, periodo_d;
  logic valido_q, valido_d, listo_q, listo_d, parado_q, parado_d;
  logic flanco, tick, acepta;
  sincro_flanco u_sincro (
    .Reloj (Reloj),
    .nReset(nReset),
    .in    (Pulso),
    .flanco(flanco)
  );
  always_comb begin
    tick      = pre_q == PRE_FIN;
    cont_inc  = (tick && cont_q != CONT_MAX) ? cont_q + 1'b1 : cont_q;
    acepta    = state_q == ST_MIDIENDO && flanco && cont_q >= CONT_MIN;
    state_d   = state_q;
    pre_d     = tick ? '0 : pre_q + 1'b1;
    cont_d    = cont_inc;
    periodo_d = periodo_q;
    valido_d  = 1'b0;
    listo_d   = listo_q;
    parado_d  = parado_q;
    if (state_q == ST_INICIO) begin
      cont_d = '0;
      if (flanco) begin
        pre_d   = PRE_ARR;
        state_d = ST_MIDIENDO;
      end
    end else if (acepta) begin
      periodo_d = cont_q;
      valido_d  = 1'b1;
      listo_d   = 1'b1;
      parado_d  = 1'b0;
      cont_d    = '0;
      pre_d     = PRE_ARR;
    end else if (cont_inc == CONT_MAX) begin
      state_d  = ST_INICIO;
      parado_d = 1'b1;
      listo_d  = 1'b0;
    end
  end
  always_ff @(posedge Reloj or negedge nReset)
    if (!nReset) begin
      state_q   <= ST_INICIO;
      pre_q     <= '0;
      cont_q    <= '0;
      periodo_q <= '0;
      valido_q  <= 1'b0;
      listo_q   <= 1'b0;
      parado_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cont_q    <= cont_d;
      periodo_q <= periodo_d;
      valido_q  <= valido_d;
      listo_q   <= listo_d;
      parado_q  <= parado_d;
    end
  assign Periodo = periodo_q;
  assign Valido  = valido_q;
  assign Listo   = listo_q;
  assign Parado  = parado_q;
endmodule
